mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one pipeline request at a time, lane-aligned
// memory strobe with timeout, and an extended/flagged response handshake.
module mem_access_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [2:0] {
    OP_LW = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010, OP_LB = 3'b011,
    OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH = 3'b110, OP_SB = 3'b111
  } op_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [3:0] TMO_LAST    = 4'(MEM_TIMEOUT - 1);

  state_t      state, state_n;
  op_t         op_q;
  logic [1:0]  lane_q;
  logic [3:0]  wait_cnt;

  logic        req_mis;
  logic        req_store;
  logic [3:0]  req_be;
  logic [31:0] req_lane_wdata;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic        timeout;

  assign mem_en     = (state == ACCESS);
  assign resp_valid = (state == RESP);
  assign req_ready  = (state == IDLE) && reset;
  assign timeout    = (wait_cnt == TMO_LAST);

  // Request decode: alignment check, byte enables and lane replication.
  always_comb begin
    req_mis        = 1'b0;
    req_store      = 1'b0;
    req_be         = '0;
    req_lane_wdata = '0;
    unique case (op_t'(req_op))
      OP_LW:         req_mis = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU: req_mis = req_addr[0];
      OP_SW: begin
        req_mis        = (req_addr[1:0] != 2'b00);
        req_store      = 1'b1;
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
      end
      OP_SH: begin
        req_mis        = req_addr[0];
        req_store      = 1'b1;
        req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      OP_SB: begin
        req_store      = 1'b1;
        req_be         = 4'b0001 << req_addr[1:0];
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Halfword loads are always lane 0 or 2 here, so one shifted view serves both sizes.
  always_comb begin
    rd_shift = mem_rdata >> {lane_q, 3'b000};
    load_val = '0;
    unique case (op_q)
      OP_LW:  load_val = mem_rdata;
      OP_LH:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU: load_val = {16'h0000, rd_shift[15:0]};
      OP_LB:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU: load_val = {24'h000000, rd_shift[7:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = req_mis ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timeout) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_LW;
      lane_q     <= '0;
      wait_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          op_q       <= op_t'(req_op);
          lane_q     <= req_addr[1:0];
          wait_cnt   <= '0;
          mem_we     <= req_store;
          mem_addr   <= {req_addr[31:2], 2'b00};
          mem_be     <= req_be;
          mem_wdata  <= req_lane_wdata;
          resp_rdata <= '0;
          resp_err   <= req_mis ? ERR_MISALGN : ERR_OK;
        end
        ACCESS: begin
          if (mem_ack) begin
            resp_rdata <= load_val;
            resp_err   <= ERR_OK;
          end else if (timeout) begin
            resp_rdata <= '0;
            resp_err   <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized transactions
// against a byte-level reference model, and reset-abort sequences.
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;   // ACCESS cycle carrying mem_ack; 0 = never
    int          rdy_dly;   // cycles resp_ready is held low
    logic [1:0]  err;
    logic [31:0] rx;
    logic [3:0]  be;
    logic [31:0] mwd;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, wdata, rdata,
                              input int ack_cyc, rdy_dly, input logic [1:0] err,
                              input logic [31:0] rx, input logic [3:0] be,
                              input logic [31:0] mwd, input int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_cyc = ack_cyc; v.rdy_dly = rdy_dly;
    v.err = err; v.rx = rx; v.be = be; v.mwd = mwd; v.lat = lat;
    return v;
  endfunction

  // Reference: access size/offset arithmetic over bytes, no FSM.
  function automatic vec_t model(input logic [2:0] op, input logic [31:0] addr, wdata, rdata,
                                 input int ack_cyc, rdy_dly);
    vec_t v;
    int size, off;
    bit store, sgn;
    longint val;
    v = mk(op, addr, wdata, rdata, ack_cyc, rdy_dly, 2'b00, 32'h0, 4'h0, 32'h0, 0);
    store = (op >= 3'd5);
    sgn   = (op == 3'd1) || (op == 3'd3);
    size  = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    off   = int'(addr[1:0]);
    if (store)
      for (int i = 0; i < 4; i++) begin
        v.be[i] = (i >= off) && (i < off + size);
        v.mwd[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
    if (off % size != 0) begin
      v.err = 2'b01; v.lat = 1;
    end else if (ack_cyc >= 1 && ack_cyc <= TMO) begin
      v.err = 2'b00; v.lat = 1 + ack_cyc;
      if (!store) begin
        val = 0;
        for (int b = 0; b < size; b++) val += longint'(rdata[8*(off+b) +: 8]) << (8*b);
        if (sgn && val >= (longint'(1) << (8*size-1))) val -= (longint'(1) << (8*size));
        v.rx = val[31:0];
      end
    end else begin
      v.err = 2'b10; v.lat = 1 + TMO;
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    int lat, en_cnt;
    bit got, store, mis;
    store = (v.op >= 3'd5);
    mis   = (v.err == 2'b01);
    lat = 0; en_cnt = 0; got = 0;
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      chk("onehot", {31'b0, (int'(mem_en) + int'(resp_valid) + int'(req_ready)) <= 1}, 1);
      if (resp_valid) begin lat = n; got = 1; break; end
      if (mem_en) begin
        en_cnt++;
        chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("mem_we", {31'b0, mem_we}, {31'b0, store});
        chk("mem_be", {28'b0, mem_be}, {28'b0, v.be});
        if (store) chk("mem_wdata", mem_wdata, v.mwd);
      end
      mem_ack   = mem_en && (n == v.ack_cyc);
      mem_rdata = mem_ack ? v.rdata : $urandom;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_wait got=none want=resp_valid op=%0d addr=%h", v.op, v.addr);
      mem_ack = 1'b0;
      return;
    end
    chk("latency", lat, v.lat);
    chk("en_cycles", en_cnt, mis ? 0 : v.lat - 1);
    chk("resp_err", {30'b0, resp_err}, {30'b0, v.err});
    chk("resp_rdata", resp_rdata, v.rx);
    for (int j = 0; j <= v.rdy_dly; j++) begin
      if (j > 0) begin
        @(negedge clk);
        chk("hold_valid", {31'b0, resp_valid}, 1);
        chk("hold_rdata", resp_rdata, v.rx);
        chk("hold_err", {30'b0, resp_err}, {30'b0, v.err});
      end
      resp_ready = (j == v.rdy_dly);
      mem_ack    = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    resp_ready = 1'b0; mem_ack = 1'b0;
    chk("done_valid", {31'b0, resp_valid}, 0);
    chk("done_ready", {31'b0, req_ready}, 1);
  endtask

  initial begin
    vec_t v;
    bit seen;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;

    tbl[0]  = mk(3'd7, 32'h13,  32'hA5,       32'h0,        1, 0, 2'b00, 32'h0,        4'b1000, 32'hA5A5A5A5, 2);
    tbl[1]  = mk(3'd3, 32'h22,  32'h0,        32'h12F45678, 1, 0, 2'b00, 32'hFFFFFFF4, 4'b0000, 32'h0,        2);
    tbl[2]  = mk(3'd4, 32'h22,  32'h0,        32'h12F45678, 1, 0, 2'b00, 32'h000000F4, 4'b0000, 32'h0,        2);
    tbl[3]  = mk(3'd2, 32'h22,  32'h0,        32'h12F45678, 1, 0, 2'b00, 32'h000012F4, 4'b0000, 32'h0,        2);
    tbl[4]  = mk(3'd0, 32'h06,  32'h0,        32'h0,        1, 0, 2'b01, 32'h0,        4'b0000, 32'h0,        1);
    tbl[5]  = mk(3'd0, 32'h100, 32'h0,        32'h55AA55AA, 0, 1, 2'b10, 32'h0,        4'b0000, 32'h0,        16);
    tbl[6]  = mk(3'd0, 32'h104, 32'h0,        32'hCAFEBABE, 15, 0, 2'b00, 32'hCAFEBABE, 4'b0000, 32'h0,       16);
    tbl[7]  = mk(3'd6, 32'h42,  32'hBEEF,     32'h0,        1, 3, 2'b00, 32'h0,        4'b1100, 32'hBEEFBEEF, 2);
    tbl[8]  = mk(3'd1, 32'h40,  32'h0,        32'h00018000, 3, 0, 2'b00, 32'hFFFF8000, 4'b0000, 32'h0,        4);
    tbl[9]  = mk(3'd5, 32'h41,  32'h1234,     32'h0,        1, 0, 2'b01, 32'h0,        4'b0000, 32'h0,        1);
    tbl[10] = mk(3'd6, 32'h43,  32'h1234,     32'h0,        1, 2, 2'b01, 32'h0,        4'b0000, 32'h0,        1);
    tbl[11] = mk(3'd7, 32'h0,   32'h1234565A, 32'h0,        2, 0, 2'b00, 32'h0,        4'b0001, 32'h5A5A5A5A, 3);
    tbl[12] = mk(3'd5, 32'h200, 32'hDEADBEEF, 32'h0,        1, 0, 2'b00, 32'h0,        4'b1111, 32'hDEADBEEF, 2);
    tbl[13] = mk(3'd3, 32'h7,   32'h0,        32'h7F000000, 1, 0, 2'b00, 32'h0000007F, 4'b0000, 32'h0,        2);
    tbl[14] = mk(3'd1, 32'h2,   32'h0,        32'h80000000, 1, 0, 2'b00, 32'hFFFF8000, 4'b0000, 32'h0,        2);
    tbl[15] = mk(3'd7, 32'h0,   32'h11,       32'h0,        0, 0, 2'b10, 32'h0,        4'b0001, 32'h11111111, 16);

    #2;
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_err", {30'b0, resp_err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_ready", {31'b0, req_ready}, 1);

    for (int i = 0; i < 16; i++) run(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      int ack;
      ack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(1, 4));
      v = model(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, ack,
                int'($urandom_range(0, 3)));
      run(v);
    end

    // Reset mid-ACCESS: strobe drops at once, no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h300; mem_ack = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_en", {31'b0, mem_en}, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_en", {31'b0, mem_en}, 0);
    chk("abort_valid", {31'b0, resp_valid}, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort_ready_after", {31'b0, req_ready}, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || mem_en) seen = 1;
    end
    chk("abort_no_resp", {31'b0, seen}, 0);

    // Reset while a response is waiting.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h6; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("resp_pre_valid", {31'b0, resp_valid}, 1);
    reset = 1'b0;
    #1;
    chk("resp_abort_valid", {31'b0, resp_valid}, 0);
    chk("resp_abort_err", {30'b0, resp_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("resp_abort_ready", {31'b0, req_ready}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

endmodule
